// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the soc_system input PIO: register map and edge-mode encodings.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Picks the edge event of interest for a given EDGE_MODE encoding.
  function automatic logic edge_select(input int mode, input logic rise, input logic fall);
    case (mode)
      EDGE_RISE: edge_select = rise;
      EDGE_FALL: edge_select = fall;
      default:   edge_select = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input bit: two-flop synchroniser followed by a consecutive-cycle debounce filter.
module soc_system_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic db,
  output logic accept,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             db_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Accept fires in the cycle before db flips, so edge capture lands on the same edge as db.
  assign accept = (s2_reg != db_reg) && (cnt_reg == CNT_LAST);
  assign rise   = accept & s2_reg;
  assign fall   = accept & ~s2_reg;
  assign db     = db_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg  <= 1'b0;
      s2_reg  <= 1'b0;
      db_reg  <= 1'b0;
      cnt_reg <= '0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
      if (s2_reg != db_reg) begin
        if (accept) begin
          db_reg  <= s2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO with per-bit debounce, edge capture (W1C) and a maskable level interrupt.
module soc_system_pio_in_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int EDGE_MODE       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;

  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] edge_clear;
  logic [31:0]      readdata_reg;

  logic wr_en;
  logic unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign unused_writedata = ^writedata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      soc_system_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (in_port[gi]),
        .db    (db[gi]),
        .accept(accept[gi]),
        .rise  (rise[gi]),
        .fall  (fall[gi])
      );
      assign edge_set[gi] = accept[gi] & edge_select(EDGE_MODE, rise[gi], fall[gi]);
    end
  endgenerate

  // A new edge on a bit overrides a simultaneous W1C of that same bit.
  always_comb begin
    edge_clear = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      edge_clear = writedata[WIDTH-1:0];
    end
    edge_capture_next = (edge_capture_reg & ~edge_clear) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_reg     <= '0;
      edge_capture_reg <= '0;
    end else begin
      edge_capture_reg <= edge_capture_next;
      if (wr_en && (address == ADDR_MASK)) begin
        irq_mask_reg <= writedata[WIDTH-1:0];
      end
    end
  end

  // Read data is refreshed every cycle from the addressed register; reads have no side effects.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= '0;
    end else begin
      case (address)
        ADDR_DATA: readdata_reg <= 32'(db);
        ADDR_MASK: readdata_reg <= 32'(irq_mask_reg);
        ADDR_EDGE: readdata_reg <= 32'(edge_capture_reg);
        default:   readdata_reg <= '0;
      endcase
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Directed bench: vector table on a fast rising-edge instance, hand sequences on a debounced any-edge instance.
module tb_soc_system_pio_in_edge;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [1:0]  address;
  logic        cs_a, cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  in_a, in_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0)) dut_a (
    .clk(clk), .reset(rst_a), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a)
  );

  soc_system_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut_b (
    .clk(clk), .reset(rst_b), .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b)
  );

  typedef struct {
    logic [7:0]  in_val;
    logic        do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = ~sel;
    cs_b      = sel;
    tick();
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic run_vec(input int i);
    in_a = vecs[i].in_val;
    if (vecs[i].do_wr) bus_write(1'b0, vecs[i].waddr, vecs[i].wdata);
    address = vecs[i].raddr;
    repeat (5) tick();
    check32({vecs[i].name, "_rd"}, rd_a, vecs[i].exp_rd);
    check1({vecs[i].name, "_irq"}, irq_a, vecs[i].exp_irq);
  endtask

  initial begin
    //                 in     wr    wa    wdata        ra    exp_rd       irq
    vecs[0]  = '{8'h00, 1'b0, 2'd0, 32'h0,       2'd0, 32'h0,       1'b0, "rst_data"};
    vecs[1]  = '{8'h00, 1'b0, 2'd0, 32'h0,       2'd2, 32'h0,       1'b0, "rst_mask"};
    vecs[2]  = '{8'h00, 1'b0, 2'd0, 32'h0,       2'd3, 32'h0,       1'b0, "rst_edge"};
    vecs[3]  = '{8'h00, 1'b1, 2'd2, 32'h01,      2'd2, 32'h01,      1'b0, "mask_wr"};
    vecs[4]  = '{8'h01, 1'b0, 2'd0, 32'h0,       2'd0, 32'h01,      1'b0, "data_hi"};
    vecs[5]  = '{8'h00, 1'b0, 2'd0, 32'h0,       2'd3, 32'h0,       1'b0, "fall_ignored"};
    vecs[6]  = '{8'h06, 1'b0, 2'd0, 32'h0,       2'd3, 32'h06,      1'b0, "rise_unmasked"};
    vecs[7]  = '{8'h06, 1'b1, 2'd0, 32'hFF,      2'd0, 32'h06,      1'b0, "data_ro"};
    vecs[8]  = '{8'h06, 1'b1, 2'd1, 32'hFF,      2'd1, 32'h0,       1'b0, "rsvd"};
    vecs[9]  = '{8'h06, 1'b1, 2'd3, 32'h02,      2'd3, 32'h04,      1'b0, "w1c_iso"};
    vecs[10] = '{8'h00, 1'b0, 2'd0, 32'h0,       2'd3, 32'h04,      1'b0, "fall_keep"};
    vecs[11] = '{8'h00, 1'b1, 2'd2, 32'h04,      2'd2, 32'h04,      1'b1, "mask_irq"};
    vecs[12] = '{8'h00, 1'b1, 2'd3, 32'hFF,      2'd3, 32'h0,       1'b0, "w1c_all"};
    vecs[13] = '{8'h81, 1'b0, 2'd0, 32'h0,       2'd3, 32'h81,      1'b0, "rise_two"};
    vecs[14] = '{8'h81, 1'b1, 2'd2, 32'hFFFFFF80, 2'd2, 32'h80,     1'b1, "mask_hi"};

    rst_a = 1'b1; rst_b = 1'b1;
    address = 2'd0; cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1; writedata = '0;
    in_a = '0; in_b = '0;
    repeat (3) tick();
    check32("a_rd_in_reset", rd_a, 32'h0);
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(i);

    // Exact latency of a rising edge on the undebounced instance, then W1C timing.
    address = 2'd3;
    in_a = 8'h01;
    tick();
    tick();
    check1("a_irq_e1", irq_a, 1'b0);
    tick();
    check1("a_irq_e2", irq_a, 1'b1);
    check32("a_ec_rd_e2", rd_a, 32'h0);
    tick();
    check32("a_ec_rd_e3", rd_a, 32'h01);
    bus_write(1'b0, 2'd3, 32'h01);
    check1("a_w1c_irq", irq_a, 1'b0);
    tick();
    check32("a_w1c_rd", rd_a, 32'h0);

    for (int i = 4; i < 15; i++) run_vec(i);

    // Glitch of 3 cycles at the synchroniser output must be rejected.
    in_b = 8'h08;
    repeat (3) tick();
    in_b = 8'h00;
    address = 2'd0;
    repeat (10) tick();
    check32("b_glitch_data", rd_b, 32'h0);
    address = 2'd3;
    tick();
    check32("b_glitch_edge", rd_b, 32'h0);

    // Stable input: capture appears at edge 5, visible on readdata at edge 6.
    in_b = 8'h08;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check32("b_deb_edge5", rd_b, 32'h0);
      if (e == 6) check32("b_deb_edge6", rd_b, 32'h08);
    end
    address = 2'd0;
    tick();
    check32("b_deb_data", rd_b, 32'h08);

    // W1C of bit 1 on the very edge its new rising edge is accepted.
    in_b = 8'h0A;
    repeat (5) tick();
    bus_write(1'b1, 2'd3, 32'h02);
    tick();
    check32("b_collide", rd_b, 32'h0A);

    // Masking with every capture bit set.
    in_b = 8'hFF;
    repeat (10) tick();
    check32("b_ec_all", rd_b, 32'hFF);
    check1("b_mask0_irq", irq_b, 1'b0);
    bus_write(1'b1, 2'd2, 32'h80);
    check1("b_mask80_irq", irq_b, 1'b1);
    tick();
    check32("b_mask_rd", rd_b, 32'h80);
    bus_write(1'b1, 2'd0, 32'h0);
    bus_write(1'b1, 2'd1, 32'h0);
    address = 2'd3;
    tick();
    check32("b_ro_ec", rd_b, 32'hFF);
    address = 2'd0;
    tick();
    check32("b_ro_data", rd_b, 32'hFF);
    address = 2'd2;
    tick();
    check32("b_ro_mask", rd_b, 32'h80);

    // Reset with inputs high: they re-appear as rising edges after release.
    rst_b = 1'b1;
    tick();
    tick();
    check32("b_rst_rd", rd_b, 32'h0);
    check1("b_rst_irq", irq_b, 1'b0);
    rst_b = 1'b0;
    address = 2'd0;
    repeat (10) tick();
    check32("b_rst_hi_data", rd_b, 32'hFF);
    address = 2'd3;
    tick();
    check32("b_rst_hi_rise", rd_b, 32'hFF);
    address = 2'd2;
    tick();
    check32("b_rst_mask", rd_b, 32'h0);
    check1("b_rst_mask_irq", irq_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_pio_in_edge.md
# soc_system_pio_in_edge

Parametrised Avalon-MM input PIO for the soc_system fabric. It gives the HPS a multi-bit input port with synchronisation, per-bit debounce, per-bit edge capture and a maskable interrupt. It is the next-generation replacement for the single-bit, level-only input PIOs. It is used for flags such as volume, key and switch status, where software needs latched edge events rather than polling.

## Interface
Parameters:
- WIDTH, 8, number of input bits (1..32).
- DEBOUNCE_CYCLES, 1, number of consecutive cycles a synchronised change must persist before it is accepted (1..65535). A value of 1 means no filtering.
- EDGE_MODE, 2, edge type captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs only when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt = |(edge_capture & irq_mask).

## Operation
- Register map:
  - 0: data, read-only; returns the debounced value (db). Writes are ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2: irq_mask, read/write, WIDTH bits.
  - 3: edge_capture, read; writing 1 to a bit clears that bit.
- Per-bit input path:
  - in_port → s1 → s2 (2-flop synchroniser) → debounce → db.
- Debounce, per bit:
  - cnt counts consecutive cycles with s2≠db.
  - When s2≠db and cnt==DEBOUNCE_CYCLES-1: db<=s2 and cnt<=0.
  - When s2==db: cnt<=0.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- Edge detect:
  - Evaluated on the accepting cycle, i.e. the cycle in which db is about to change.
  - rise = accept & s2; fall = accept & ~s2; the EDGE_MODE parameter selects between them.
  - A detected edge sets the corresponding edge_capture bit.
- Set and clear in the same cycle on the same bit: set wins.
- Clear of bit i has no effect on other bits.
- readdata is updated every clock from the mux selected by address, whether or not a read is in progress. Read has no side effects.
- Reset:
  - s1, s2, db, cnt, irq_mask, edge_capture and readdata all go to 0, so irq=0.
  - An input that is high when reset releases is therefore seen as a rising edge after the normal latency.
  - Reset asserted mid-debounce discards the count.

## Timing
- The input change is sampled at clock edge 0.
- s2 is valid after edge 1.
- db and edge_capture update at edge 1+DEBOUNCE_CYCLES.
- irq asserts in the same cycle (combinational from registers).
- Address 0 readdata reflects the new value at edge 2+DEBOUNCE_CYCLES.
- Read latency is 1 cycle: address presented before edge k produces readdata valid after edge k.
- A write takes effect at the same edge, so a readback at the next address cycle shows the written value.
- A W1C write at edge k: irq deasserts after edge k, unless a new edge on a masked-in bit is set at edge k.
- A glitch shorter than DEBOUNCE_CYCLES cycles at s2 leaves db, edge_capture and irq unchanged.

## Structure
- Shared package soc_system_pio_pkg holds:
  - register address constants (ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3);
  - EDGE_MODE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module soc_system_pio_debounce implements one bit: synchroniser, counter, db and the accept/rise/fall outputs. It is parametrised by DEBOUNCE_CYCLES and instantiated WIDTH times in a generate loop.
- The top level holds the Avalon decode, irq_mask, edge_capture, readdata mux and irq.

## Test plan
- **Reset:** WIDTH=8, DEBOUNCE_CYCLES=1, in_port=0.
  - Release reset, read addresses 0/2/3 → all 0x00000000; irq=0.
- **Rising edge and interrupt:** EDGE_MODE=0, mask=0x01.
  - in_port 0x00→0x01 → edge_capture=0x01 and irq=1 at edge 2; data reads 0x01.
  - in_port 0x01→0x00 → no new capture.
  - Write 0x01 to address 3 → irq=0.
- **Debounce:** DEBOUNCE_CYCLES=4.
  - A 3-cycle pulse on bit 3 → data stays 0x00 and edge_capture stays 0.
  - A 4-cycle-stable pulse → db bit 3 set at edge 5 and edge_capture=0x08.
- **Set and clear collide:** EDGE_MODE=2.
  - W1C 0x02 in the same cycle that a new edge on bit 1 is accepted → edge_capture bit 1 remains 1.
- **Masking:** mask=0x00 with edge_capture=0xFF → irq=0.
  - Write mask=0x80 → irq=1 after the write edge.
  - Readback of address 2 = 0x00000080.
  - Writes to addresses 0 and 1 → no state change.
